// File: rtl/atm_cell_rx.sv
// UTOPIA-style ATM cell receiver: assembles 53-byte cells and hands them off with valid/ready.
// Build with ATM_HEC_CHECK_EN defined to drop cells whose header HEC does not match.
module atm_cell_rx #(
    parameter int unsigned IfWidth = 8
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [IfWidth-1:0] data,
    input  logic               soc,
    input  logic               clav,
    output logic               en,
    output logic [423:0]       ATMCell,
    output logic               valid,
    input  logic               ready,
    output logic               hec_err,
    output logic [15:0]        cell_cnt
);

    typedef enum logic [1:0] {StIdle, StAssemble, StHold} state_e;

    state_e         state_q, state_d;
    logic   [5:0]   cnt_q, cnt_d;
    logic   [423:0] cell_q, cell_d;
    logic           valid_q, valid_d;
    logic   [15:0]  cell_cnt_q, cell_cnt_d;
    logic   [5:0]   rev_idx;
    logic   [8:0]   byte_lsb;
    logic           hec_ok;

`ifdef ATM_HEC_CHECK_EN
    logic hec_err_q, hec_err_d;

    // ATM HEC: CRC-8 with polynomial x^8+x^2+x+1, zero init, header bits MSB first.
    function automatic logic [7:0] crc8(input logic [31:0] hdr);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            if (crc[7] ^ hdr[i]) begin
                crc = {crc[6:0], 1'b0} ^ 8'h07;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc;
    endfunction

    assign hec_ok  = (cell_q[391:384] == (crc8(cell_q[423:392]) ^ 8'h55));
    assign hec_err = hec_err_q;
`else
    assign hec_ok  = 1'b1;
    assign hec_err = 1'b0;
`endif

    assign ATMCell  = cell_q;
    assign valid    = valid_q;
    assign cell_cnt = cell_cnt_q;

    // Byte n of the cell lives at bits [423-8n -: 8].
    assign rev_idx  = 6'd52 - cnt_q;
    assign byte_lsb = {rev_idx, 3'b000};

    always_comb begin
        en = 1'b1;
        if (!reset && (state_q != StHold) && clav) begin
            en = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cell_d     = cell_q;
        valid_d    = valid_q;
        cell_cnt_d = cell_cnt_q;
`ifdef ATM_HEC_CHECK_EN
        hec_err_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!en && soc) begin
                    cell_d[423:416] = data;
                    cnt_d           = 6'd1;
                    state_d         = StAssemble;
                end
            end
            StAssemble: begin
                if (!en) begin
                    if (soc) begin
                        cell_d[423:416] = data;
                        cnt_d           = 6'd1;
                    end else begin
                        cell_d[byte_lsb +: 8] = data;
                        cnt_d                 = cnt_q + 6'd1;
                        if (cnt_q == 6'd52) begin
                            cnt_d = 6'd0;
                            if (hec_ok) begin
                                state_d = StHold;
                                valid_d = 1'b1;
                            end else begin
                                state_d = StIdle;
`ifdef ATM_HEC_CHECK_EN
                                hec_err_d = 1'b1;
`endif
                            end
                        end
                    end
                end
            end
            StHold: begin
                if (ready) begin
                    valid_d    = 1'b0;
                    state_d    = StIdle;
                    cell_cnt_d = cell_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 6'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 6'd0;
            cell_q     <= '0;
            valid_q    <= 1'b0;
            cell_cnt_q <= 16'd0;
`ifdef ATM_HEC_CHECK_EN
            hec_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cell_q     <= cell_d;
            valid_q    <= valid_d;
            cell_cnt_q <= cell_cnt_d;
`ifdef ATM_HEC_CHECK_EN
            hec_err_q  <= hec_err_d;
`endif
        end
    end

endmodule
